// File: rtl/pr2_pkg.sv
// ID/EX pipeline register (PR2) layout shared by the writer and every EX-stage reader.
// The bit positions are fixed because downstream consumers hard-code them.
package pr2_pkg;

    localparam int unsigned PR_W  = 500;
    localparam int unsigned DW    = 64;
    localparam int unsigned CNT_W = 16;

    localparam int unsigned PR2_PC_LO       = 0;
    localparam int unsigned PR2_PC_HI       = 63;
    localparam int unsigned PR2_INSTR_LO    = 64;
    localparam int unsigned PR2_INSTR_HI    = 95;
    localparam int unsigned PR2_ALUSRC      = 96;
    localparam int unsigned PR2_REGWRITE    = 97;
    localparam int unsigned PR2_MEMREAD     = 98;
    localparam int unsigned PR2_MEMWRITE    = 99;
    localparam int unsigned PR2_MEMTOREG    = 100;
    localparam int unsigned PR2_BRANCH      = 101;
    localparam int unsigned PR2_ALUOP_LO    = 102;
    localparam int unsigned PR2_ALUOP_HI    = 103;
    localparam int unsigned PR2_CTRL_LO     = 96;
    localparam int unsigned PR2_CTRL_HI     = 103;
    localparam int unsigned PR2_DATA1_LO    = 104;
    localparam int unsigned PR2_DATA1_HI    = 167;
    localparam int unsigned PR2_DATA2_LO    = 168;
    localparam int unsigned PR2_DATA2_HI    = 231;
    localparam int unsigned PR2_SEOUT_LO    = 232;
    localparam int unsigned PR2_SEOUT_HI    = 295;
    localparam int unsigned PR2_RD_LO       = 296;
    localparam int unsigned PR2_RD_HI       = 300;
    localparam int unsigned PR2_VALID       = 301;
    localparam int unsigned PR2_RSVD_LO     = 302;
    localparam int unsigned PR2_RSVD_HI     = 499;

    // Member order puts alusrc at the LSB so the struct maps directly onto [103:96].
    typedef struct packed {
        logic [1:0] aluop;
        logic       branch;
        logic       memtoreg;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic       alusrc;
    } ctrl_t;

    typedef enum logic {
        StRun,
        StHeld
    } state_t;

    function automatic logic [PR_W-1:0] pack_pr2(
        input logic [DW-1:0] pc,
        input logic [31:0]   instr,
        input ctrl_t         ctrl,
        input logic [DW-1:0] data1,
        input logic [DW-1:0] data2,
        input logic [DW-1:0] seout,
        input logic [4:0]    rd,
        input logic          valid
    );
        logic [PR_W-1:0] r;
        r = '0;
        r[PR2_PC_HI:PR2_PC_LO]       = pc;
        r[PR2_INSTR_HI:PR2_INSTR_LO] = instr;
        r[PR2_CTRL_HI:PR2_CTRL_LO]   = ctrl;
        r[PR2_DATA1_HI:PR2_DATA1_LO] = data1;
        r[PR2_DATA2_HI:PR2_DATA2_LO] = data2;
        r[PR2_SEOUT_HI:PR2_SEOUT_LO] = seout;
        r[PR2_RD_HI:PR2_RD_LO]       = rd;
        r[PR2_VALID]                 = valid;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-stage inputs and packed PR2 outputs of the ID/EX pipeline register.
interface id_ex_pipe_reg_if;
    import pr2_pkg::*;

    logic                stall;
    logic                flush;
    logic                in_valid;
    logic [DW-1:0]       pc_in;
    logic [31:0]         instr_in;
    logic                alusrc_in;
    logic                regwrite_in;
    logic                memread_in;
    logic                memwrite_in;
    logic                memtoreg_in;
    logic                branch_in;
    logic [1:0]          aluop_in;
    logic [DW-1:0]       data1_in;
    logic [DW-1:0]       data2_in;
    logic [DW-1:0]       seout_in;
    logic [4:0]          rd_in;
    logic [PR_W-1:0]     pr2;
    logic                pr2_valid;
    logic [CNT_W-1:0]    bubble_count;

    modport master (
        output stall, flush, in_valid, pc_in, instr_in, alusrc_in, regwrite_in,
               memread_in, memwrite_in, memtoreg_in, branch_in, aluop_in,
               data1_in, data2_in, seout_in, rd_in,
        input  pr2, pr2_valid, bubble_count
    );

    modport slave (
        input  stall, flush, in_valid, pc_in, instr_in, alusrc_in, regwrite_in,
               memread_in, memwrite_in, memtoreg_in, branch_in, aluop_in,
               data1_in, data2_in, seout_in, rd_in,
        output pr2, pr2_valid, bubble_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [Width-1:0] o_count
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + Width'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: packs decode data/controls into PR2 with stall hold,
// flush bubbles and a saturating bubble counter.
module id_ex_pipe_reg
    import pr2_pkg::*;
(
    input logic           clk,
    input logic           reset,
    id_ex_pipe_reg_if.slave bus
);

    ctrl_t           w_ctrl;
    logic            w_valid;
    logic            w_load;
    logic [PR_W-1:0] w_pr2_d;
    logic [PR_W-1:0] r_pr2;
    state_t          r_state;

    always_comb begin
        w_ctrl.aluop    = bus.aluop_in;
        w_ctrl.branch   = bus.branch_in;
        w_ctrl.memtoreg = bus.memtoreg_in;
        w_ctrl.memwrite = bus.memwrite_in;
        w_ctrl.memread  = bus.memread_in;
        w_ctrl.regwrite = bus.regwrite_in;
        w_ctrl.alusrc   = bus.alusrc_in;
        // Bubbles and non-instructions must never carry side-effecting controls into EX.
        if (bus.flush || !bus.in_valid) begin
            w_ctrl = '0;
        end
        w_valid = bus.in_valid && !bus.flush;
        w_load  = bus.flush || !bus.stall;
        w_pr2_d = pack_pr2(bus.pc_in, bus.instr_in, w_ctrl, bus.data1_in, bus.data2_in,
                           bus.seout_in, bus.rd_in, w_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pr2   <= '0;
            r_state <= StRun;
        end else begin
            if (w_load) begin
                r_pr2 <= w_pr2_d;
            end
            case (r_state)
                StRun:   if (bus.stall && !bus.flush) r_state <= StHeld;
                StHeld:  if (!bus.stall || bus.flush) r_state <= StRun;
                default: r_state <= StRun;
            endcase
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (bus.flush),
        .o_count (bus.bubble_count)
    );

    assign bus.pr2       = r_pr2;
    assign bus.pr2_valid = r_pr2[PR2_VALID];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised scoreboard bench for id_ex_pipe_reg against a field-level reference model.
module tb_id_ex_pipe_reg;

    typedef struct {
        logic [499:0] pr2;
        logic [15:0]  cnt;
    } exp_t;

    logic clk;
    logic reset;

    id_ex_pipe_reg_if bus ();

    id_ex_pipe_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    exp_t         exp_q[$];
    logic [499:0] m_pr2;
    logic [15:0]  m_cnt;

    // Stimulus field values for the next cycle.
    logic        f_iv;
    logic [63:0] f_pc;
    logic [31:0] f_instr;
    logic        f_alusrc, f_regwrite, f_memread, f_memwrite, f_memtoreg, f_branch;
    logic [1:0]  f_aluop;
    logic [63:0] f_d1, f_d2, f_se;
    logic [4:0]  f_rd;

    function automatic logic [499:0] build(input logic [7:0] ctrl, input logic v);
        logic [499:0] r;
        r = '0;
        r[63:0]    = f_pc;
        r[95:64]   = f_instr;
        r[103:96]  = ctrl;
        r[167:104] = f_d1;
        r[231:168] = f_d2;
        r[295:232] = f_se;
        r[300:296] = f_rd;
        r[301]     = v;
        return r;
    endfunction

    task automatic check500(input string name, input logic [499:0] got, input logic [499:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic rand_fields();
        f_iv       = 1'($urandom);
        f_pc       = {$urandom, $urandom};
        f_instr    = $urandom;
        f_alusrc   = 1'($urandom);
        f_regwrite = 1'($urandom);
        f_memread  = 1'($urandom);
        f_memwrite = 1'($urandom);
        f_memtoreg = 1'($urandom);
        f_branch   = 1'($urandom);
        f_aluop    = 2'($urandom);
        f_d1       = {$urandom, $urandom};
        f_d2       = {$urandom, $urandom};
        f_se       = {$urandom, $urandom};
        f_rd       = 5'($urandom);
    endtask

    // One clock of stimulus: drive at the falling edge, predict the post-edge state.
    task automatic cycle(input logic st, input logic fl);
        logic [7:0] ctrl;
        @(negedge clk);
        bus.stall       = st;
        bus.flush       = fl;
        bus.in_valid    = f_iv;
        bus.pc_in       = f_pc;
        bus.instr_in    = f_instr;
        bus.alusrc_in   = f_alusrc;
        bus.regwrite_in = f_regwrite;
        bus.memread_in  = f_memread;
        bus.memwrite_in = f_memwrite;
        bus.memtoreg_in = f_memtoreg;
        bus.branch_in   = f_branch;
        bus.aluop_in    = f_aluop;
        bus.data1_in    = f_d1;
        bus.data2_in    = f_d2;
        bus.seout_in    = f_se;
        bus.rd_in       = f_rd;
        ctrl = {f_aluop, f_branch, f_memtoreg, f_memwrite, f_memread, f_regwrite, f_alusrc};
        if (fl) begin
            m_pr2 = build(8'h00, 1'b0);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (!st) begin
            m_pr2 = build(f_iv ? ctrl : 8'h00, f_iv);
        end
        exp_q.push_back('{pr2: m_pr2, cnt: m_cnt});
    endtask

    // Monitor: compare every registered output against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check500("pr2", bus.pr2, e.pr2);
                check16("pr2_valid", {15'd0, bus.pr2_valid}, {15'd0, e.pr2[301]});
                check16("bubble_count", bus.bubble_count, e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        rand_fields();
        f_iv = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        m_pr2 = '0;
        m_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check500("reset_pr2", bus.pr2, '0);
        check16("reset_valid", {15'd0, bus.pr2_valid}, 16'd0);
        check16("reset_count", bus.bubble_count, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed load
        rand_fields();
        f_iv = 1'b1; f_alusrc = 1'b1; f_d2 = 64'hAAAA; f_se = 64'h5;
        cycle(1'b0, 1'b0);

        // Stall hold for three edges, then release loads new inputs
        rand_fields();
        f_iv = 1'b1; f_pc = 64'h100;
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            cycle(1'b1, 1'b0);
        end
        rand_fields();
        cycle(1'b0, 1'b0);

        // Flush bubble, then flush with stall
        rand_fields();
        f_iv = 1'b1; f_regwrite = 1'b1; f_memwrite = 1'b1; f_aluop = 2'b10;
        cycle(1'b0, 1'b1);
        rand_fields();
        f_iv = 1'b1;
        cycle(1'b1, 1'b0);
        rand_fields();
        f_iv = 1'b1;
        cycle(1'b1, 1'b1);

        // Random mix of stall/flush/in_valid
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
        end

        // Async reset between edges while stalled with nonzero contents
        rand_fields();
        f_iv = 1'b1;
        cycle(1'b0, 1'b1);
        rand_fields();
        cycle(1'b1, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check500("async_reset_pr2", bus.pr2, '0);
        check16("async_reset_count", bus.bubble_count, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        m_pr2 = '0;
        m_cnt = '0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Saturation: 65535 flushes reach all-ones, further flushes stay there
        for (int i = 0; i < 65537; i++) begin
            rand_fields();
            cycle(1'b0, 1'b1);
        end
        rand_fields();
        cycle(1'b1, 1'b1);
        rand_fields();
        cycle(1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Writer side of the ID/EX pipeline register bus `PR2`. All EX-stage consumers (ALUSrc mux, ALU, forwarding) read fields from it.
- Samples decode-stage data and controls each cycle and packs them into the fixed 500-bit PR2 layout.
- Supports stall (hold), flush (bubble insertion) and a valid bit.
- Keeps a saturating count of inserted bubbles for simulation statistics.

Parameters:
- PR_W, 500, total PR2 width in bits
- DW, 64, datapath / register data width
- CNT_W, 16, bubble counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold current PR2 contents
- flush  input  1  replace next PR2 with a bubble
- in_valid  input  1  decode stage presents a real instruction
- pc_in  input  64  instruction address
- instr_in  input  32  raw instruction word
- alusrc_in  input  1  0 = Data2 feeds ALU B, 1 = sign-extended immediate
- regwrite_in  input  1  write-back enable
- memread_in  input  1  load
- memwrite_in  input  1  store
- memtoreg_in  input  1  write-back select
- branch_in  input  1  conditional/unconditional branch
- aluop_in  input  2  ALU operation class
- data1_in  input  64  register file read port 1
- data2_in  input  64  register file read port 2
- seout_in  input  64  sign-extend unit output
- rd_in  input  5  destination register
- pr2  output  500  packed ID/EX register
- pr2_valid  output  1  copy of PR2[301]
- bubble_count  output  16  saturating count of flush-inserted bubbles

Behaviour:
- PR2 layout (fixed; consumers hard-code these bit positions):
  - [63:0] PC
  - [95:64] instr
  - [96] ALUSrc
  - [97] RegWrite
  - [98] MemRead
  - [99] MemWrite
  - [100] MemtoReg
  - [101] Branch
  - [103:102] ALUOp
  - [167:104] Data1
  - [231:168] Data2
  - [295:232] SEout
  - [300:296] Rd
  - [301] valid
  - [499:302] reserved, always 0
- Reset (asynchronous, takes effect without a clock edge): pr2 = 0, pr2_valid = 0, bubble_count = 0. Reset asserted mid-operation discards any held or stalled contents immediately.
- Latency: one cycle. Inputs sampled at rising edge N appear on pr2 after edge N.
- Per-edge priority, highest first:
  1. flush = 1 → bubble: bits [103:96] = 0, [301] = 0. Data, PC, instr and Rd fields load normally so debug tracing stays meaningful. bubble_count increments.
  2. stall = 1 → pr2 holds all 500 bits unchanged; bubble_count unchanged.
  3. otherwise → load all fields; [301] = in_valid.
- flush and stall both asserted: flush wins.
- in_valid = 0 without flush: control bits [103:96] are forced to 0, same as a bubble, but bubble_count does not increment.
- bubble_count saturates at 2^CNT_W − 1 and does not wrap. A flush at saturation leaves it unchanged.
- Reserved bits are never driven nonzero under any input combination.
- No combinational path from any input to pr2. Outputs are purely registered.
- Internal state machine, two states:
  - RUN: pr2 updates.
  - HELD: entered when stall = 1 at an edge; exits to RUN on the first edge with stall = 0 or flush = 1.
  - The state is exported only via the hold behaviour. It is documented so verification can cover the transitions.

Decomposition:
- Shared package `pr2_pkg`:
  - localparam bit positions and ranges for every PR2 field (PR2_PC_LO/HI, PR2_ALUSRC = 96, PR2_DATA2_LO = 168, PR2_SEOUT_LO = 232, PR2_VALID = 301, …)
  - PR_W
  - a packed struct typedef of the control byte [103:96]
- The ALUSrc mux and other EX readers import the same package.
- One sub-module: `sat_counter` (parameterised width, inc enable, async reset), used for bubble_count.

Test Plan:
- Reset then load: assert reset, release; drive in_valid = 1, alusrc = 1, data2 = 64'hAAAA, seout = 64'h5 → after one edge pr2[96] = 1, pr2[231:168] = 64'hAAAA, pr2[295:232] = 5, pr2[301] = 1, pr2[499:302] = 0.
- Stall hold: load pc = 64'h100, assert stall 3 cycles while changing all inputs → pr2 unchanged for 3 edges; first edge after release loads the new inputs.
- Flush bubble: regwrite = 1, memwrite = 1, aluop = 2'b10, flush = 1 → pr2[103:96] = 0, pr2[301] = 0, data fields loaded, bubble_count 0 → 1.
- Flush + stall simultaneously: both = 1 → bubble inserted (not held); bubble_count increments.
- Saturation: preload by 65535 flushes, apply one more flush → bubble_count stays 16'hFFFF.
- Async reset mid-stall: stall held with pr2 nonzero, pulse reset between clock edges → pr2 = 0 and bubble_count = 0 immediately, before the next edge.
